// File: rtl/cache_line_fetch_ctrl_pkg.sv
// Shared types and constants for the cache line fetch controller.
// Ready codes follow the 4-word line memory protocol.
package cache_line_fetch_ctrl_pkg;

  localparam int unsigned ADDR_W      = 16;
  localparam int unsigned WORD_W      = 16;
  localparam int unsigned LINE_WORDS  = 4;
  localparam int unsigned LINE_W      = WORD_W * LINE_WORDS;
  localparam int unsigned STAT_W      = 16;
  localparam int unsigned TIMEOUT_DEF = 64;

  typedef logic [1:0] rdy_t;

  localparam rdy_t RDY_IDLE = 2'd2;
  localparam rdy_t RDY_BUSY = 2'd0;
  localparam rdy_t RDY_DONE = 2'd1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WB_WAIT,
    ST_RD_WAIT,
    ST_RESP,
    ST_ERR
  } state_t;

  // Increment that sticks at all-ones.
  function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
    return (v == '1) ? v : v + STAT_W'(1);
  endfunction

  // Clear the word-offset bits of a word address.
  function automatic logic [ADDR_W-1:0] line_align(input logic [ADDR_W-1:0] a);
    return a & ~ADDR_W'(LINE_WORDS - 1);
  endfunction

endpackage

// File: rtl/cache_line_fetch_ctrl_req_watchdog.sv
// Request watchdog: counts cycles spent waiting on memory and flags expiry.
// clear has priority; expired holds until the next clear.
module cache_line_fetch_ctrl_req_watchdog #(
  parameter int unsigned TIMEOUT = 64
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk) begin
    if (!reset_n || clear) begin
      count   <= '0;
      expired <= 1'b0;
    end else if (enable && !expired) begin
      count   <= count + CNT_W'(1);
      expired <= (count == CNT_W'(TIMEOUT - 1));
    end
  end

endmodule

// File: rtl/cache_line_fetch_ctrl.sv
// Cache miss handler: optional dirty-victim writeback, then line fetch and fill.
// One miss in flight; memory requests use 2-bit ready codes.
module cache_line_fetch_ctrl
  import cache_line_fetch_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              miss_valid,
  output logic              miss_ready,
  input  logic [ADDR_W-1:0] miss_addr,
  input  logic              miss_dirty,
  input  logic [ADDR_W-1:0] victim_addr,
  input  logic [LINE_W-1:0] victim_line,
  output logic              fill_valid,
  output logic [ADDR_W-1:0] fill_addr,
  output logic [LINE_W-1:0] fill_line,
  output logic              mem_read,
  output logic [ADDR_W-1:0] mem_raddr,
  input  logic [1:0]        mem_rd_ready,
  input  logic [LINE_W-1:0] mem_rdata,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_waddr,
  output logic [LINE_W-1:0] mem_wdata,
  input  logic [1:0]        mem_wr_ready,
  output logic              err,
  output logic [STAT_W-1:0] num_fills,
  output logic [STAT_W-1:0] num_wbacks
);

  state_t state;
  logic   seen_busy;
  logic   wr_done_c;
  logic   rd_done_c;
  logic   wd_clear;
  logic   wd_enable;
  logic   wd_expired;

  // DONE only counts once the current request has been seen BUSY.
  assign wr_done_c = (state == ST_WB_WAIT) && mem_write && seen_busy &&
                     (mem_wr_ready == RDY_DONE);
  assign rd_done_c = (state == ST_RD_WAIT) && mem_read && seen_busy &&
                     (mem_rd_ready == RDY_DONE);

  assign wd_clear  = (state == ST_IDLE) || wr_done_c;
  assign wd_enable = (state == ST_WB_WAIT) || (state == ST_RD_WAIT);

  cache_line_fetch_ctrl_req_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (wd_clear),
    .enable  (wd_enable),
    .expired (wd_expired)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state      <= ST_IDLE;
      miss_ready <= 1'b1;
      fill_valid <= 1'b0;
      fill_addr  <= '0;
      fill_line  <= '0;
      mem_read   <= 1'b0;
      mem_raddr  <= '0;
      mem_write  <= 1'b0;
      mem_waddr  <= '0;
      mem_wdata  <= '0;
      err        <= 1'b0;
      num_fills  <= '0;
      num_wbacks <= '0;
      seen_busy  <= 1'b0;
    end else begin
      fill_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (miss_valid && miss_ready) begin
            mem_raddr  <= line_align(miss_addr);
            mem_waddr  <= line_align(victim_addr);
            mem_wdata  <= victim_line;
            miss_ready <= 1'b0;
            state      <= miss_dirty ? ST_WB_WAIT : ST_RD_WAIT;
          end
        end
        ST_WB_WAIT: begin
          if (wd_expired) begin
            mem_write <= 1'b0;
            err       <= 1'b1;
            state     <= ST_ERR;
          end else if (wr_done_c) begin
            mem_write  <= 1'b0;
            num_wbacks <= sat_inc(num_wbacks);
            state      <= ST_RD_WAIT;
            // Read channel is already idle-sampled here, so the read can issue at once.
            if (mem_rd_ready == RDY_IDLE) begin
              mem_read  <= 1'b1;
              seen_busy <= 1'b0;
            end
          end else if (!mem_write) begin
            if (mem_wr_ready == RDY_IDLE) begin
              mem_write <= 1'b1;
              seen_busy <= 1'b0;
            end
          end else if (mem_wr_ready == RDY_BUSY) begin
            seen_busy <= 1'b1;
          end
        end
        ST_RD_WAIT: begin
          if (wd_expired) begin
            mem_read <= 1'b0;
            err      <= 1'b1;
            state    <= ST_ERR;
          end else if (rd_done_c) begin
            mem_read   <= 1'b0;
            fill_line  <= mem_rdata;
            fill_addr  <= mem_raddr;
            fill_valid <= 1'b1;
            state      <= ST_RESP;
          end else if (!mem_read) begin
            if (mem_rd_ready == RDY_IDLE) begin
              mem_read  <= 1'b1;
              seen_busy <= 1'b0;
            end
          end else if (mem_rd_ready == RDY_BUSY) begin
            seen_busy <= 1'b1;
          end
        end
        ST_RESP: begin
          num_fills  <= sat_inc(num_fills);
          miss_ready <= 1'b1;
          state      <= ST_IDLE;
        end
        ST_ERR: begin
          miss_ready <= 1'b0;
          err        <= 1'b1;
        end
        default: begin
          state <= ST_ERR;
          err   <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cache_line_fetch_ctrl.sv
// Self-checking bench for cache_line_fetch_ctrl: directed table, corner sequences,
// and randomized misses against a line-level memory reference.
module tb_cache_line_fetch_ctrl;

  localparam logic [1:0] C_IDLE = 2'd2;
  localparam logic [1:0] C_BUSY = 2'd0;
  localparam logic [1:0] C_DONE = 2'd1;
  localparam int BUSY_CYC = 4;
  localparam int NLINES   = 16384;

  logic        clk;
  logic        reset_n;
  logic        miss_valid;
  logic        miss_ready;
  logic [15:0] miss_addr;
  logic        miss_dirty;
  logic [15:0] victim_addr;
  logic [63:0] victim_line;
  logic        fill_valid;
  logic [15:0] fill_addr;
  logic [63:0] fill_line;
  logic        mem_read;
  logic [15:0] mem_raddr;
  logic [1:0]  mem_rd_ready;
  logic [63:0] mem_rdata;
  logic        mem_write;
  logic [15:0] mem_waddr;
  logic [63:0] mem_wdata;
  logic [1:0]  mem_wr_ready;
  logic        err;
  logic [15:0] num_fills;
  logic [15:0] num_wbacks;

  cache_line_fetch_ctrl dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .miss_valid   (miss_valid),
    .miss_ready   (miss_ready),
    .miss_addr    (miss_addr),
    .miss_dirty   (miss_dirty),
    .victim_addr  (victim_addr),
    .victim_line  (victim_line),
    .fill_valid   (fill_valid),
    .fill_addr    (fill_addr),
    .fill_line    (fill_line),
    .mem_read     (mem_read),
    .mem_raddr    (mem_raddr),
    .mem_rd_ready (mem_rd_ready),
    .mem_rdata    (mem_rdata),
    .mem_write    (mem_write),
    .mem_waddr    (mem_waddr),
    .mem_wdata    (mem_wdata),
    .mem_wr_ready (mem_wr_ready),
    .err          (err),
    .num_fills    (num_fills),
    .num_wbacks   (num_wbacks)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int overlap  = 0;
  int exp_fills = 0;
  int exp_wb    = 0;

  logic [63:0] mem     [NLINES];
  logic [63:0] ref_mem [NLINES];
  int rd_left, wr_left;
  bit rd_stuck, rd_manual;

  typedef struct {
    logic [15:0] addr;
    logic        dirty;
    logic [15:0] vaddr;
    logic [63:0] vline;
    logic [15:0] efa;
    logic [63:0] efl;
    int          elat;
  } vec_t;

  vec_t vt [5];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] dflt_line(input int i);
    logic [15:0] b;
    b = 16'(32'hA000 + 4 * i);
    return {b + 16'd3, b + 16'd2, b + 16'd1, b};
  endfunction

  // Line memory responder: IDLE -> BUSY x4 -> DONE (one cycle) -> IDLE.
  task automatic mem_update(input logic rq, input logic [15:0] ra,
                            input logic wq, input logic [15:0] wa, input logic [63:0] wd);
    if (!rd_manual) begin
      case (mem_rd_ready)
        C_IDLE: if (rq) begin mem_rd_ready = C_BUSY; rd_left = BUSY_CYC - 1; end
        C_BUSY: if (!rd_stuck) begin
          if (rd_left == 0) begin
            mem_rd_ready = C_DONE;
            mem_rdata    = mem[ra[15:2]];
          end else rd_left--;
        end
        default: begin mem_rd_ready = C_IDLE; mem_rdata = {$urandom, $urandom}; end
      endcase
    end
    case (mem_wr_ready)
      C_IDLE: if (wq) begin mem_wr_ready = C_BUSY; wr_left = BUSY_CYC - 1; end
      C_BUSY: begin
        if (wr_left == 0) begin
          mem_wr_ready   = C_DONE;
          mem[wa[15:2]]  = wd;
        end else wr_left--;
      end
      default: mem_wr_ready = C_IDLE;
    endcase
  endtask

  task automatic step();
    logic rq, wq;
    logic [15:0] ra, wa;
    logic [63:0] wd;
    rq = mem_read; wq = mem_write; ra = mem_raddr; wa = mem_waddr; wd = mem_wdata;
    @(posedge clk);
    #1;
    mem_update(rq, ra, wq, wa, wd);
    if (mem_read && mem_write) overlap++;
  endtask

  task automatic mem_idle();
    rd_stuck = 0; rd_manual = 0;
    mem_rd_ready = C_IDLE; mem_wr_ready = C_IDLE;
    rd_left = 0; wr_left = 0;
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_miss_ready"}, 64'(miss_ready), 64'd1);
    chk({tag, "_fill_valid"}, 64'(fill_valid), 64'd0);
    chk({tag, "_fill_addr"},  64'(fill_addr),  64'd0);
    chk({tag, "_fill_line"},  fill_line,       64'd0);
    chk({tag, "_mem_read"},   64'(mem_read),   64'd0);
    chk({tag, "_mem_raddr"},  64'(mem_raddr),  64'd0);
    chk({tag, "_mem_write"},  64'(mem_write),  64'd0);
    chk({tag, "_mem_waddr"},  64'(mem_waddr),  64'd0);
    chk({tag, "_mem_wdata"},  mem_wdata,       64'd0);
    chk({tag, "_err"},        64'(err),        64'd0);
    chk({tag, "_num_fills"},  64'(num_fills),  64'd0);
    chk({tag, "_num_wbacks"}, 64'(num_wbacks), 64'd0);
  endtask

  // One complete miss; expected values come from the caller.
  task automatic do_miss(input string tag, input logic [15:0] a, input logic d,
                         input logic [15:0] va, input logic [63:0] vl,
                         input logic [15:0] efa, input logic [63:0] efl, input int elat);
    int k, wr_first, rd_first;
    bit got;
    logic [15:0] ra, wa;
    logic [63:0] wd;
    k = 0;
    while (!miss_ready && k < 50) begin step(); k++; end
    chk({tag, "_ready"}, 64'(miss_ready), 64'd1);
    miss_valid = 1; miss_addr = a; miss_dirty = d; victim_addr = va; victim_line = vl;
    step();
    miss_valid = 0; miss_addr = 16'($urandom); miss_dirty = 1'($urandom);
    victim_addr = 16'($urandom); victim_line = {$urandom, $urandom};
    got = 0; wr_first = -1; rd_first = -1; k = 0; ra = '0; wa = '0; wd = '0;
    while (!got && k < 200) begin
      step(); k++;
      if (mem_write && wr_first < 0) begin wr_first = k; wa = mem_waddr; wd = mem_wdata; end
      if (mem_read && rd_first < 0) begin rd_first = k; ra = mem_raddr; end
      if (fill_valid) got = 1;
    end
    chk({tag, "_fill_seen"}, 64'(got), 64'd1);
    chk({tag, "_latency"},   64'(k), 64'(elat));
    chk({tag, "_fill_addr"}, 64'(fill_addr), 64'(efa));
    chk({tag, "_fill_line"}, fill_line, efl);
    chk({tag, "_raddr"},     64'(ra), 64'(efa));
    if (d) begin
      chk({tag, "_waddr"}, 64'(wa), 64'(va & 16'hFFFC));
      chk({tag, "_wdata"}, wd, vl);
      chk({tag, "_wr_before_rd"}, 64'((wr_first > 0) && (rd_first > wr_first)), 64'd1);
      exp_wb++;
    end else begin
      chk({tag, "_no_write"}, 64'(wr_first), 64'hFFFF_FFFF_FFFF_FFFF);
    end
    exp_fills++;
    step();
    chk({tag, "_pulse_one"},  64'(fill_valid), 64'd0);
    chk({tag, "_idle_ready"}, 64'(miss_ready), 64'd1);
    chk({tag, "_num_fills"},  64'(num_fills),  64'(exp_fills));
    chk({tag, "_num_wbacks"}, 64'(num_wbacks), 64'(exp_wb));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "bench timeout");
  end

  initial begin
    int k, nf;
    logic [15:0] a, va, f1a;
    logic [63:0] vl, f1l;
    logic d;
    bit got, early;

    for (int i = 0; i < NLINES; i++) begin
      mem[i] = dflt_line(i);
      ref_mem[i] = dflt_line(i);
    end
    mem[9] = 64'h6200_F41C_6100_F01C;
    ref_mem[9] = 64'h6200_F41C_6100_F01C;

    vt[0] = '{16'h0025, 1'b0, 16'h0000, 64'h0, 16'h0024, 64'h6200_F41C_6100_F01C, 7};
    vt[1] = '{16'h0010, 1'b1, 16'h0031, 64'hDDDD_CCCC_BBBB_AAAA, 16'h0010, 64'hA013_A012_A011_A010, 13};
    vt[2] = '{16'h0033, 1'b0, 16'h0000, 64'h0, 16'h0030, 64'hDDDD_CCCC_BBBB_AAAA, 7};
    vt[3] = '{16'h0102, 1'b1, 16'h0103, 64'h1234_5678_9ABC_DEF0, 16'h0100, 64'h1234_5678_9ABC_DEF0, 13};
    vt[4] = '{16'hFFFF, 1'b0, 16'h0000, 64'h0, 16'hFFFC, 64'h9FFF_9FFE_9FFD_9FFC, 7};

    reset_n = 0; miss_valid = 0; miss_addr = '0; miss_dirty = 0;
    victim_addr = '0; victim_line = '0; mem_rdata = '0;
    mem_idle();
    repeat (3) step();
    check_reset("rst");
    reset_n = 1;
    step();
    chk("rst_release_ready", 64'(miss_ready), 64'd1);

    for (int i = 0; i < 5; i++) begin
      do_miss($sformatf("vec%0d", i), vt[i].addr, vt[i].dirty, vt[i].vaddr, vt[i].vline,
              vt[i].efa, vt[i].efl, vt[i].elat);
      if (vt[i].dirty) ref_mem[vt[i].vaddr[15:2]] = vt[i].vline;
    end
    chk("wb_mem_0030", mem[12], 64'hDDDD_CCCC_BBBB_AAAA);

    // Back-to-back misses with miss_valid held high.
    miss_valid = 1; miss_addr = 16'h0040; miss_dirty = 0;
    step();
    miss_addr = 16'h0044;
    k = 0; nf = 0; f1a = '0; f1l = '0;
    while (!miss_ready && k < 50) begin
      step(); k++;
      if (fill_valid) begin f1a = fill_addr; f1l = fill_line; nf++; end
    end
    chk("b2b_first_fills", 64'(nf), 64'd1);
    chk("b2b_ready_back",  64'(k), 64'd8);
    chk("b2b_first_addr",  64'(f1a), 64'h0040);
    chk("b2b_first_line",  f1l, 64'hA043_A042_A041_A040);
    step();
    miss_valid = 0;
    chk("b2b_second_taken", 64'(miss_ready), 64'd0);
    got = 0; k = 0;
    while (!got && k < 50) begin step(); k++; if (fill_valid) got = 1; end
    chk("b2b_second_seen", 64'(got), 64'd1);
    chk("b2b_second_addr", 64'(fill_addr), 64'h0044);
    chk("b2b_second_line", fill_line, 64'hA047_A046_A045_A044);
    exp_fills += 2;
    step();
    chk("b2b_num_fills", 64'(num_fills), 64'(exp_fills));

    // Stale DONE on the issue cycle must be ignored.
    rd_manual = 1; mem_rd_ready = C_IDLE;
    miss_valid = 1; miss_addr = 16'h0052; miss_dirty = 0;
    step();
    miss_valid = 0;
    k = 0;
    while (!mem_read && k < 20) begin step(); k++; end
    chk("stale_issued", 64'(mem_read), 64'd1);
    mem_rd_ready = C_DONE; mem_rdata = 64'hBAD0_BAD1_BAD2_BAD3;
    step();
    early = fill_valid;
    chk("stale_req_held", 64'(mem_read), 64'd1);
    for (int i = 0; i < 4; i++) begin
      mem_rd_ready = C_BUSY; mem_rdata = {$urandom, $urandom};
      step();
      early = early | fill_valid;
    end
    chk("stale_no_early_fill", 64'(early), 64'd0);
    mem_rd_ready = C_DONE; mem_rdata = 64'h600D_600D_1234_4321;
    step();
    chk("stale_fill_valid", 64'(fill_valid), 64'd1);
    chk("stale_fill_line",  fill_line, 64'h600D_600D_1234_4321);
    chk("stale_fill_addr",  64'(fill_addr), 64'h0050);
    mem_rd_ready = C_IDLE; mem_rdata = '0;
    step();
    chk("stale_req_dropped", 64'(mem_read), 64'd0);
    exp_fills++;
    rd_manual = 0;
    step();

    // Randomized misses over a small window so victims and misses collide.
    for (int n = 0; n < 30; n++) begin
      a  = 16'h0200 | 16'($urandom_range(0, 63));
      va = 16'h0200 | 16'($urandom_range(0, 63));
      d  = 1'($urandom_range(0, 1));
      vl = {$urandom, $urandom};
      if (d) ref_mem[va[15:2]] = vl;
      do_miss($sformatf("rnd%0d", n), a, d, va, vl, a & 16'hFFFC, ref_mem[a[15:2]], d ? 13 : 7);
      repeat ($urandom_range(0, 3)) step();
    end

    // Reset pulsed during writeback.
    miss_valid = 1; miss_addr = 16'h0300; miss_dirty = 1;
    victim_addr = 16'h0304; victim_line = 64'h0123_4567_89AB_CDEF;
    step();
    miss_valid = 0;
    repeat (3) step();
    chk("wbrst_in_write", 64'(mem_write), 64'd1);
    reset_n = 0;
    step();
    reset_n = 1;
    chk("wbrst_write_drop", 64'(mem_write), 64'd0);
    check_reset("wbrst");
    exp_fills = 0; exp_wb = 0;
    got = 0;
    for (int i = 0; i < 20; i++) begin step(); got = got | fill_valid | mem_read | mem_write; end
    chk("wbrst_quiet", 64'(got), 64'd0);
    chk("wbrst_fills_zero", 64'(num_fills), 64'd0);
    chk("wbrst_wbacks_zero", 64'(num_wbacks), 64'd0);

    // Memory stuck BUSY: watchdog raises err and drops the request.
    mem_idle();
    rd_stuck = 1;
    miss_valid = 1; miss_addr = 16'h0061; miss_dirty = 0;
    step();
    miss_valid = 0;
    for (int i = 1; i <= 70; i++) begin
      step();
      if (i == 60) begin
        chk("stuck_err_early", 64'(err), 64'd0);
        chk("stuck_req_held",  64'(mem_read), 64'd1);
      end
    end
    chk("stuck_err",        64'(err), 64'd1);
    chk("stuck_req_drop",   64'(mem_read), 64'd0);
    chk("stuck_miss_ready", 64'(miss_ready), 64'd0);
    chk("stuck_no_write",   64'(mem_write), 64'd0);
    repeat (3) step();
    chk("stuck_err_sticky", 64'(err), 64'd1);
    mem_idle();
    reset_n = 0;
    step();
    reset_n = 1;
    check_reset("errrst");

    chk("no_rd_wr_overlap", 64'(overlap), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
